// File: rtl/stream_source.sv
// Burst transmitter on the valid/grant stream: one command (base, step, length)
// produces an arithmetic sequence of words, advancing only on granted cycles.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready_o high
//   SEND  | presenting words, valid_o high
module stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_base_i,
    input  logic [DATA_WIDTH-1:0] cmd_step_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  abort_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  grant_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [LEN_WIDTH-1:0]  sent_cnt_o
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] step_q, step_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [LEN_WIDTH-1:0]  sent_q, sent_d;
    logic                  abort_q, abort_d;
    logic                  done_q, done_d;
    logic                  aborted_q, aborted_d;
    logic                  xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            step_q    <= '0;
            remain_q  <= '0;
            sent_q    <= '0;
            abort_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            step_q    <= step_d;
            remain_q  <= remain_d;
            sent_q    <= sent_d;
            abort_q   <= abort_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        step_d    = step_q;
        remain_d  = remain_q;
        sent_d    = sent_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        aborted_d = aborted_q;
        xfer      = (state_q == SEND) && grant_i;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    sent_d    = '0;
                    aborted_d = 1'b0;
                    abort_d   = 1'b0;
                    if (cmd_len_i != '0) begin
                        state_d  = SEND;
                        data_d   = cmd_base_i;
                        step_d   = cmd_step_i;
                        remain_d = cmd_len_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    data_d   = data_q + step_q;
                    sent_d   = sent_q + LEN_ONE;
                    remain_d = remain_q - LEN_ONE;
                    // An abort landing on the natural final word still counts as a normal finish.
                    if (remain_q == LEN_ONE || abort_q || abort_i) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        aborted_d = (remain_q != LEN_ONE);
                    end
                end else if (abort_i) begin
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign valid_o     = (state_q == SEND);
    assign busy_o      = (state_q == SEND);
    assign last_o      = (state_q == SEND) && (remain_q == LEN_ONE || abort_q);
    assign data_o      = data_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign sent_cnt_o  = sent_q;

endmodule

// File: tb/tb_stream_source.sv
// Bench for stream_source: table of directed bursts, random bursts against an
// arithmetic model (word k = base + k*step), plus reset corner sequences.
module tb_stream_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [31:0] cmd_base_i;
    logic [31:0] cmd_step_i;
    logic [7:0]  cmd_len_i;
    logic        abort_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        grant_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;
    logic [7:0]  sent_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_source #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_i(cmd_base_i), .cmd_step_i(cmd_step_i), .cmd_len_i(cmd_len_i),
        .abort_i(abort_i), .data_o(data_o), .valid_o(valid_o), .grant_i(grant_i),
        .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
        .sent_cnt_o(sent_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          len;
        int          gmode;       // 0: grant always, 1: low 5 cycles then toggle, 2: random
        int          abort_idx;   // word index presented when abort pulses, -1 for none
        logic        abort_grant; // grant value in the abort cycle
        int          exp_n;
        logic        exp_aborted;
    } vec_t;

    // Runs one burst from the negedge before acceptance until done has been checked.
    task automatic run_burst(input vec_t v);
        int   idx = 0;
        int   cyc = 0;
        logic active;
        logic pending = 1'b0;
        logic g, a, fin, ab;
        logic exp_ab = 1'b0;

        @(negedge clk);
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_base_i  = v.base;
        cmd_step_i  = v.step;
        cmd_len_i   = v.len[7:0];
        @(negedge clk);
        cmd_valid_i = 1'b0;
        active = (v.len > 0);
        while (active) begin
            check("valid", valid_o, 1);
            check("busy", busy_o, 1);
            check("cmd_ready_send", cmd_ready_o, 0);
            check("done_mid", done_o, 0);
            check("data", data_o, v.base + v.step * idx);
            check("last", last_o, (idx == v.len - 1) || pending);
            check("sent_mid", sent_cnt_o, idx);
            case (v.gmode)
                0:       g = 1'b1;
                1:       g = (cyc >= 5) && ((cyc - 5) % 2 == 0);
                default: g = 1'($urandom_range(0, 1));
            endcase
            a = (v.abort_idx == idx) && !pending;
            if (a) g = v.abort_grant;
            // Extra cmd_valid while busy must be ignored.
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_len_i   = 8'd0;
            grant_i = g;
            abort_i = a;
            if (g) begin
                fin = (idx == v.len - 1) || a || pending;
                ab  = (idx != v.len - 1) && (a || pending);
                idx++;
                if (fin) begin
                    active = 1'b0;
                    exp_ab = ab;
                end
            end else if (a) begin
                pending = 1'b1;
            end
            cyc++;
            if (cyc > 400) begin
                check("burst_timeout", 1, 0);
                active = 1'b0;
            end
            @(negedge clk);
            abort_i = 1'b0;
            cmd_valid_i = 1'b0;
        end
        grant_i = 1'($urandom_range(0, 1));
        check("valid_end", valid_o, 0);
        check("done_pulse", done_o, 1);
        check("aborted", aborted_o, exp_ab);
        check("aborted_table", aborted_o, v.exp_aborted);
        check("sent_final", sent_cnt_o, v.exp_n);
        check("sent_model", sent_cnt_o, idx);
        check("cmd_ready_end", cmd_ready_o, 1);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        check("valid_after", valid_o, 0);
        check("aborted_held", aborted_o, exp_ab);
        grant_i = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        vec_t rv;
        int   n, k;

        tbl[0] = '{32'hA5A5A5A5, 32'd1, 4,  0, -1, 1'b1, 4,  1'b0};
        tbl[1] = '{32'h5A5A5A5A, 32'd2, 3,  1, -1, 1'b1, 3,  1'b0};
        tbl[2] = '{32'hFFFFFFFE, 32'd1, 3,  0, -1, 1'b1, 3,  1'b0};
        tbl[3] = '{32'h12345678, 32'd7, 0,  0, -1, 1'b1, 0,  1'b0};
        tbl[4] = '{32'h00000000, 32'd1, 10, 0, 3,  1'b0, 4,  1'b1};
        tbl[5] = '{32'h00000100, 32'd3, 6,  0, 2,  1'b1, 3,  1'b1};
        tbl[6] = '{32'h80000000, 32'hFFFFFFFF, 5, 0, 4, 1'b1, 5, 1'b0};

        rst = 1'b1; cmd_valid_i = 1'b0; cmd_base_i = '0; cmd_step_i = '0;
        cmd_len_i = '0; abort_i = 1'b0; grant_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_valid", valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_aborted", aborted_o, 0);
        check("rst_last", last_o, 0);
        check("rst_data", data_o, 0);
        check("rst_sent", sent_cnt_o, 0);
        check("rst_ready", cmd_ready_o, 1);

        // Abort and grant in IDLE must have no effect.
        abort_i = 1'b1; grant_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; grant_i = 1'b0;
        check("idle_abort_valid", valid_o, 0);
        check("idle_abort_done", done_o, 0);

        foreach (tbl[i]) run_burst(tbl[i]);

        // Reset in the middle of an 8-word burst after two transfers.
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_base_i = 32'h1000; cmd_step_i = 32'h10; cmd_len_i = 8'd8;
        @(negedge clk);
        cmd_valid_i = 1'b0; grant_i = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_sent", sent_cnt_o, 2);
        check("pre_rst_data", data_o, 32'h1020);
        grant_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_sent", sent_cnt_o, 0);
        check("mid_rst_ready", cmd_ready_o, 1);
        check("mid_rst_done", done_o, 0);
        run_burst('{32'hCAFE0000, 32'd5, 2, 0, -1, 1'b1, 2, 1'b0});

        // Random bursts checked against the arithmetic model.
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(0, 20));
            k = ($urandom_range(0, 2) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
            rv.base = $urandom;
            rv.step = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9));
            rv.len = n;
            rv.gmode = int'($urandom_range(0, 2));
            rv.abort_idx = k;
            rv.abort_grant = 1'($urandom_range(0, 1));
            if (k >= 0 && k < n - 1) begin
                rv.exp_n = k + 1;
                rv.exp_aborted = 1'b1;
            end else begin
                rv.exp_n = n;
                rv.exp_aborted = 1'b0;
            end
            run_burst(rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Burst transmitter for the valid/grant stream interface used by the FIFO datapath (fifo_package).
- Accepts one command (base word, step, length) and emits a burst of words on data_o/valid_o, advancing only when the downstream receiver asserts grant.
- Serves as the upstream producer that feeds the FIFO top-level's data_i/valid_i/grant_o input port, both in the integrated design and as a reusable traffic source for benches.

Parameters:
- DATA_WIDTH, 32, width of data_o, cmd_base_i and cmd_step_i; taken from fifo_package.
- LEN_WIDTH, 8, width of cmd_len_i and sent_cnt_o; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  command can be accepted; high only in IDLE.
- cmd_base_i  input  DATA_WIDTH  first data word of the burst.
- cmd_step_i  input  DATA_WIDTH  increment added per word.
- cmd_len_i  input  LEN_WIDTH  number of words to send; 0 is legal.
- abort_i  input  1  request early termination of the current burst.
- data_o  output  DATA_WIDTH  stream data; connects to the receiver's data_i.
- valid_o  output  1  data_o holds a valid word; connects to the receiver's valid_i.
- grant_i  input  1  receiver accepts the word; driven by the receiver's grant_o.
- last_o  output  1  the presented word is the final word of the burst.
- busy_o  output  1  FSM is in SEND.
- done_o  output  1  one-cycle pulse when a burst ends.
- aborted_o  output  1  qualifies done_o: burst ended by abort; held until the next command is accepted.
- sent_cnt_o  output  LEN_WIDTH  words transferred in the current or most recent burst.

Behaviour:
- Reset values: while rst is high at a clock edge, state returns to IDLE and all outputs clear: valid_o, last_o, busy_o, done_o and aborted_o = 0; data_o and sent_cnt_o = 0; cmd_ready_o = 1 from the first cycle after reset. A reset mid-burst drops valid_o without waiting for grant; this is the only permitted violation of valid stability.
- Transfer rule: a word transfers in a cycle where valid_o and grant_i are both high at the rising edge. grant_i while valid_o is low has no effect.
- Stability rule: once valid_o rises, data_o, valid_o and last_o stay constant until the transfer cycle.

FSM states: IDLE, SEND.
- IDLE, command accepted with cmd_len_i > 0: a command is accepted when cmd_valid_i and cmd_ready_o are high at an edge (edge N). Latch base, step and len; clear sent_cnt_o and aborted_o; go to SEND. In cycle N+1, valid_o = 1 and data_o = base. Latency is one cycle.
- IDLE, command accepted with cmd_len_i = 0: no word is emitted. Stay in IDLE, clear sent_cnt_o, pulse done_o in cycle N+1 with aborted_o = 0.
- SEND, on each transfer:
  - data_o <= data_o + step, modulo 2^DATA_WIDTH (wrap-around, no saturation).
  - sent_cnt_o increments; remaining count decrements.
  - last_o is high exactly when remaining = 1.
- SEND, transfer of the last word: next cycle valid_o = 0, state = IDLE, done_o = 1, cmd_ready_o = 1. Minimum gap between bursts is therefore one idle cycle.
- abort_i while in SEND: sets an internal abort flag.
  - The word currently presented is still held until it is granted; that word becomes the final one and last_o is forced high from the next cycle if still pending.
  - After its transfer, go to IDLE with done_o = 1 and aborted_o = 1.
  - If abort_i coincides with a transfer, the just-transferred word is the final one: go to IDLE next cycle with aborted_o = 1.
  - If abort_i coincides with the natural last transfer, the burst completes normally with aborted_o = 0.
- abort_i in IDLE: ignored.
- cmd_valid_i in SEND: ignored, because cmd_ready_o = 0.
- Throughput: one word per cycle while grant_i is held high.

Test Plan:
- After reset, command base=32'hA5A5A5A5, step=1, len=4, grant_i held at 1 -> valid_o high for 4 consecutive cycles starting one cycle after accept; data = A5A5A5A5, A5A5A5A6, A5A5A5A7, A5A5A5A8; last_o only on the 4th word; done_o pulse next cycle; sent_cnt_o = 4.
- Command base=32'h5A5A5A5A, step=2, len=3, with grant_i low for 5 cycles, then toggling 1/0 -> data_o stays 5A5A5A5A with valid_o high while grant is low; words 5A5A5A5A, 5A5A5A5C, 5A5A5A5E each transfer only on grant cycles; done_o after the 3rd transfer.
- Command base=32'hFFFFFFFE, step=1, len=3, grant_i=1 -> data FFFFFFFE, FFFFFFFF, 00000000 (wrap-around).
- Command len=0 -> valid_o never rises; done_o pulses one cycle after accept; sent_cnt_o = 0; aborted_o = 0.
- Command base=0, step=1, len=10, grant_i=1, abort_i pulsed in the cycle presenting word 3 with grant_i=0 there -> word 3 held with last_o=1 until granted; then done_o=1, aborted_o=1, sent_cnt_o=4 counting words 0..3.
- rst asserted mid-burst (after 2 of 8 words transferred) -> next cycle valid_o=0, busy_o=0, sent_cnt_o=0, cmd_ready_o=1; a new command starts cleanly.
